// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
//
// WIDTH is split into NSLICE = WIDTH/SLICE slices. Each slice is a two-level
// CLA built from 4-bit groups. One slice is resolved per pipeline stage. The
// carry out of each slice is registered and feeds the next stage. Sum bits
// that are already resolved ride along in skew registers until the last stage.
//
// Optional feature macro: CLA_FLAGS_EN adds registered zf (sum == 0) and
// vf (signed overflow) outputs. Without it those ports and their logic are
// absent.
//
// Handshake (valid/ready):
//   A beat transfers on a rising edge where valid && ready are both high.
//   Once valid is raised, the source holds valid and its data stable until
//   the transfer happens. Ready may depend combinationally on the downstream
//   ready (in_ready = !out_valid | out_ready). The whole pipe advances
//   together, so a stalled output freezes every stage, including bubbles.
module cla_pipe_adder #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             pf,
  output logic             gf
`ifdef CLA_FLAGS_EN
  ,
  output logic             zf,
  output logic             vf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int NGRP   = SLICE / 4;

  // Result of resolving one slice: sum bits, carry out, slice P/G and,
  // when flags are built, the carry into the slice's top bit.
  typedef struct packed {
    logic [SLICE-1:0] s;
    logic             co;
    logic             p;
    logic             g;
`ifdef CLA_FLAGS_EN
    logic             cm;
`endif
  } slice_res_t;

  // Two-level CLA over one slice. Level one forms 4-bit group P/G, level two
  // looks ahead across groups to produce each group's carry-in; bit carries
  // inside a group are then expanded from the group carry-in.
  function automatic slice_res_t cla_slice(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             ci
  );
    slice_res_t      r;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] c;
    logic [NGRP-1:0]  gp;
    logic [NGRP-1:0]  gg;
    logic [NGRP:0]    gc;
    logic             gpre;
    p = x ^ y;
    g = x & y;
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    // Group-level lookahead; gpre is the slice generate with no carry-in.
    gc[0] = ci;
    gpre  = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
      gpre    = gg[j] | (gp[j] & gpre);
    end
    for (int j = 0; j < NGRP; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    r.s  = p ^ c;
    r.co = gc[NGRP];
    r.p  = &gp;
    r.g  = gpre;
`ifdef CLA_FLAGS_EN
    r.cm = c[SLICE-1];
`endif
    return r;
  endfunction

  // Global advance: every stage moves only when the output slot frees up.
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff    = b ^ {WIDTH{sub}};
  assign c0       = sub | cin;

  // Per-stage registers. opa/opb carry the operands forward so later stages
  // can pick out their slice; sum_q holds the already-resolved low bits.
  logic [NSLICE-1:0] vld_q;
  logic [NSLICE-1:0] car_q;
  logic [NSLICE-1:0] pacc_q;
  logic [NSLICE-1:0] gacc_q;
  logic [WIDTH-1:0]  opa_q [NSLICE];
  logic [WIDTH-1:0]  opb_q [NSLICE];
  logic [WIDTH-1:0]  sum_q [NSLICE];

  logic [NSLICE-1:0] car_d;
  logic [NSLICE-1:0] pacc_d;
  logic [NSLICE-1:0] gacc_d;
  logic [WIDTH-1:0]  sum_d [NSLICE];
  slice_res_t        res   [NSLICE];

  // Resolve each stage's slice and fold its P/G into the running word P/G.
  always_comb begin
    car_d  = '0;
    pacc_d = '0;
    gacc_d = '0;
    res[0]   = cla_slice(a[SLICE-1:0], b_eff[SLICE-1:0], c0);
    sum_d[0] = '0;
    sum_d[0][SLICE-1:0] = res[0].s;
    car_d[0]  = res[0].co;
    pacc_d[0] = res[0].p;
    gacc_d[0] = res[0].g;
    for (int k = 1; k < NSLICE; k++) begin
      res[k] = cla_slice(opa_q[k-1][k*SLICE +: SLICE],
                         opb_q[k-1][k*SLICE +: SLICE],
                         car_q[k-1]);
      sum_d[k] = sum_q[k-1];
      sum_d[k][k*SLICE +: SLICE] = res[k].s;
      car_d[k]  = res[k].co;
      pacc_d[k] = pacc_q[k-1] & res[k].p;
      gacc_d[k] = res[k].g | (res[k].p & gacc_q[k-1]);
    end
  end

  // Pipeline registers: cleared by reset, loaded together whenever adv is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      car_q  <= '0;
      pacc_q <= '0;
      gacc_q <= '0;
      for (int k = 0; k < NSLICE; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      opa_q[0] <= a;
      opb_q[0] <= b_eff;
      for (int k = 1; k < NSLICE; k++) begin
        vld_q[k] <= vld_q[k-1];
        opa_q[k] <= opa_q[k-1];
        opb_q[k] <= opb_q[k-1];
      end
      for (int k = 0; k < NSLICE; k++) begin
        sum_q[k] <= sum_d[k];
      end
      car_q  <= car_d;
      pacc_q <= pacc_d;
      gacc_q <= gacc_d;
    end
  end

`ifdef CLA_FLAGS_EN
  logic zf_q;
  logic vf_q;

  // Flags are formed at the last stage so they register alongside sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
      vf_q <= 1'b0;
    end else if (adv) begin
      zf_q <= (sum_d[NSLICE-1] == '0);
      vf_q <= res[NSLICE-1].cm ^ res[NSLICE-1].co;
    end
  end

  assign zf = zf_q;
  assign vf = vf_q;
`endif

  // The last stage's carry equals gf | (pf & c0), since its carry-in is the
  // lookahead of all lower slices from c0.
  assign out_valid = vld_q[NSLICE-1];
  assign sum       = sum_q[NSLICE-1];
  assign cout      = car_q[NSLICE-1];
  assign pf        = pacc_q[NSLICE-1];
  assign gf        = gacc_q[NSLICE-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder. Three instances (64/16, 32/8, 16/16) share the
// operand and handshake stimulus; instance 0 (64/16) drives the directed
// timing checks. Each instance has its own scoreboard against an
// arithmetic reference model.
module tb_cla_pipe_adder;

  localparam int NCFG   = 3;
  localparam int MAIN_N = 4;
  localparam int RW     = 69;  // {vf, zf, gf, pf, cout, sum[63:0]}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a_in = '0;
  logic [63:0] b_in = '0;

  logic          rdy_v   [NCFG];
  logic          ov_v    [NCFG];
  logic [RW-1:0] obs_v   [NCFG];
  int            qsize_v [NCFG];
  int            npop_v  [NCFG];

  int n_tests = 0;
  int n_fail  = 0;

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on a w-bit word.
  function automatic logic [RW-1:0] ref_model(input int w, input logic [63:0] x,
                                              input logic [63:0] y, input logic ci,
                                              input logic s);
    logic [64:0]   mask;
    logic [64:0]   xa;
    logic [64:0]   yb;
    logic [64:0]   t;
    logic [64:0]   t0;
    logic [RW-1:0] r;
    logic          c0;
    mask = (65'd1 << w) - 65'd1;
    xa   = {1'b0, x} & mask;
    yb   = (s ? {1'b0, ~y} : {1'b0, y}) & mask;
    c0   = s | ci;
    t    = xa + yb + {64'd0, c0};
    t0   = xa + yb;
    r    = '0;
    r[63:0] = t[63:0] & mask[63:0];
    r[64]   = t[w];
    r[65]   = ((xa ^ yb) == mask);
    r[66]   = t0[w];
`ifdef CLA_FLAGS_EN
    r[67]   = ((t & mask) == 65'd0);
    r[68]   = (xa[w-1] == yb[w-1]) && (t[w-1] != xa[w-1]);
`endif
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'hFFFF_FFFF_FFFF_FFFF;
      1: v = 64'h0;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'h7FFF_FFFF_FFFF_FFFF;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  for (genvar i = 0; i < NCFG; i++) begin : g_cfg
    localparam int W = (i == 0) ? 64 : (i == 1) ? 32 : 16;
    localparam int S = (i == 1) ? 8 : 16;

    logic          rdy;
    logic          ov;
    logic          co;
    logic          p;
    logic          g;
    logic          zf;
    logic          vf;
    logic [W-1:0]  s;
    logic [63:0]   s64;
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] held = '0;
    logic          stalled = 1'b0;

    cla_pipe_adder #(.WIDTH(W), .SLICE(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (rdy),
      .a         (a_in[W-1:0]),
      .b         (b_in[W-1:0]),
      .cin       (cin),
      .sub       (sub),
      .out_valid (ov),
      .out_ready (out_ready),
      .sum       (s),
      .cout      (co),
      .pf        (p),
      .gf        (g)
`ifdef CLA_FLAGS_EN
      ,
      .zf        (zf),
      .vf        (vf)
`endif
    );

`ifndef CLA_FLAGS_EN
    assign zf = 1'b0;
    assign vf = 1'b0;
`endif

    assign s64      = 64'(s);
    assign rdy_v[i] = rdy;
    assign ov_v[i]  = ov;
    assign obs_v[i] = {vf, zf, g, p, co, s64};

    // Scoreboard: sampled on the falling edge, for the handshakes of the next rising edge.
    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        exp_q.delete();
        stalled    <= 1'b0;
        qsize_v[i] <= 0;
      end else begin
        if (stalled) chk($sformatf("hold_cfg%0d", i), obs_v[i], held);
        if (ov && out_ready) begin
          if (exp_q.size() == 0) chk($sformatf("spurious_cfg%0d", i), {68'd0, ov}, '0);
          else chk($sformatf("result_cfg%0d", i), obs_v[i], exp_q.pop_front());
          npop_v[i] <= npop_v[i] + 1;
        end
        if (in_valid && rdy) exp_q.push_back(ref_model(W, a_in, b_in, cin, sub));
        stalled    <= ov && !out_ready;
        held       <= obs_v[i];
        qsize_v[i] <= exp_q.size();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat to instance 0 and hold it until accepted.
  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic s);
    logic acc;
    a_in = x; b_in = y; cin = ci; sub = s; in_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = rdy_v[0];
      tick();
    end
    if (!acc) chk("send_timeout", 69'd0, 69'd1);
    in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until instance 0 shows out_valid.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!ov_v[0] && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int            lat;
    int            idx;
    int            n0;
    int            cnt;
    int            acc_n;
    int            cyc;
    logic          pend;
    logic          acc;
    logic [RW-1:0] e;
    logic [RW-1:0] frz;
    logic [63:0]   sa [8];
    logic [63:0]   sb [8];

    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {68'd0, ov_v[0]}, '0);
    chk("rst_outputs", obs_v[0], '0);
    rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", {68'd0, rdy_v[0]}, 69'd1);

    // All-ones + 1: wraps to zero with carry out and word generate.
    out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_out(lat);
    chk("latency", 69'(lat), 69'(MAIN_N));
    e = '0; e[64] = 1'b1; e[66] = 1'b1;
`ifdef CLA_FLAGS_EN
    e[67] = 1'b1;
`endif
    chk("wrap_add", obs_v[0], e);
    tick();

    // 5 - 7 borrows.
    send(64'd5, 64'd7, 1'b0, 1'b1);
    wait_out(lat);
    e = '0; e[63:0] = 64'hFFFF_FFFF_FFFF_FFFE;
    chk("sub_borrow", obs_v[0], e);
    tick();

    // Largest positive + 1 overflows signed.
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_out(lat);
    e = '0; e[63:0] = 64'h8000_0000_0000_0000;
`ifdef CLA_FLAGS_EN
    e[68] = 1'b1;
`endif
    chk("signed_ovf", obs_v[0], e);
    tick();

    // Eight back-to-back beats with the output stalled in cycles 5-7.
    for (int k = 0; k < 8; k++) begin
      sa[k] = rnd64();
      sb[k] = rnd64();
    end
    n0  = npop_v[0];
    idx = 0;
    frz = '0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        a_in = sa[idx]; b_in = sb[idx]; cin = idx[1]; sub = idx[0];
      end
      @(negedge clk);
      if (c == 5) frz = obs_v[0];
      if (c >= 5 && c <= 7) begin
        chk("stall_in_ready", {68'd0, rdy_v[0]}, '0);
        chk("stall_out_valid", {68'd0, ov_v[0]}, 69'd1);
        if (c > 5) chk("stall_frozen", obs_v[0], frz);
      end
      if (in_valid && rdy_v[0]) idx++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 69'(npop_v[0] - n0), 69'd8);

    // Reset with three beats in flight, the oldest sitting at the output.
    out_ready = 1'b0;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    send(64'd1, 64'd2, 1'b0, 1'b0);
    send(64'd3, 64'd4, 1'b1, 1'b0);
    tick();
    chk("pre_rst_valid", {68'd0, ov_v[0]}, 69'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {68'd0, ov_v[0]}, '0);
    chk("async_outputs", obs_v[0], '0);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov_v[0]) cnt++;
      tick();
    end
    chk("no_stale_beat", 69'(cnt), '0);

    // Randomised traffic: random valid, ready and operands.
    acc_n = 0;
    cyc   = 0;
    pend  = 1'b0;
    while (acc_n < 10000 && cyc < 60000) begin
      if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a_in = rnd64();
        b_in = rnd64();
        cin  = 1'($urandom_range(0, 1));
        sub  = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && rdy_v[0];
      if (acc) acc_n++;
      pend = in_valid && !acc;
      tick();
      cyc++;
    end
    chk("rand_beats", 69'(acc_n), 69'd10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < NCFG; i++) begin
      chk($sformatf("drain_cfg%0d", i), 69'(qsize_v[i]), '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
